// File: rtl/operand_entry.sv
// operand_entry: assembles ASCII keystrokes into two packed-BCD operands plus operator,
// presenting the finished expression to the arithmetic unit over a valid/ready handshake.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   key_valid, key_code    key strobe and ASCII code
//   key_ready              entry accepts a key this cycle
//   reg_num1, cnt1         operand 1 (ones digit in [3:0]) and its digit count
//   reg_num2, cnt2         operand 2, same packing
//   sym                    operator code 8'h61..8'h64 (add/sub/mul/div)
//   op_valid, op_ready     expression handshake to the arithmetic unit
//   err                    one-cycle pulse for a rejected key
//
// Build option: define BACKSPACE_EN to make key 8'h08 delete the last entry.
module operand_entry #(
    parameter int MAX_DIGITS = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               key_valid,
    input  logic [7:0]                         key_code,
    output logic                               key_ready,
    output logic [4*MAX_DIGITS-1:0]            reg_num1,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    cnt1,
    output logic [4*MAX_DIGITS-1:0]            reg_num2,
    output logic [$clog2(MAX_DIGITS+1)-1:0]    cnt2,
    output logic [7:0]                         sym,
    output logic                               op_valid,
    input  logic                               op_ready,
    output logic                               err
);

    localparam int NW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);
    localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);
    localparam logic [CW-1:0] CONE = CW'(1);

    typedef enum logic [1:0] {OPA, OPB, DONE} state_t;

    state_t          state_q, state_d;
    logic [NW-1:0]   num1_q, num1_d;
    logic [NW-1:0]   num2_q, num2_d;
    logic [CW-1:0]   cnt1_q, cnt1_d;
    logic [CW-1:0]   cnt2_q, cnt2_d;
    logic [7:0]      sym_q, sym_d;
    logic            key_ready_q, key_ready_d;
    logic            op_valid_q, op_valid_d;
    logic            err_q, err_d;

    logic            is_digit, is_op, is_eq, is_clr, is_bs;
    logic            clear_all;
    logic [3:0]      digit;

    assign is_digit = (key_code >= 8'h30) && (key_code <= 8'h39);
    assign is_op    = (key_code >= 8'h61) && (key_code <= 8'h64);
    assign is_eq    = (key_code == 8'h65);
    assign is_clr   = (key_code == 8'h1B);
    assign is_bs    = (key_code == 8'h08);
    assign digit    = key_code[3:0];

    always_comb begin
        state_d   = state_q;
        num1_d    = num1_q;
        num2_d    = num2_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        sym_d     = sym_q;
        err_d     = 1'b0;
        clear_all = 1'b0;

        if (state_q == DONE) begin
            clear_all = op_ready;
        end else if (key_valid) begin
            unique case (1'b1)
                is_digit: begin
                    if (state_q == OPA) begin
                        if (cnt1_q < CMAX) begin
                            num1_d = {num1_q[NW-5:0], digit};
                            cnt1_d = cnt1_q + CONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        if (cnt2_q < CMAX) begin
                            num2_d = {num2_q[NW-5:0], digit};
                            cnt2_d = cnt2_q + CONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                is_op: begin
                    if (state_q == OPA) begin
                        if (cnt1_q != '0) begin
                            sym_d   = key_code;
                            state_d = OPB;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt2_q == '0) begin
                        // Operator typed twice in a row: last one wins.
                        sym_d = key_code;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                is_eq: begin
                    if (state_q == OPA || cnt2_q == '0) begin
                        err_d = 1'b1;
                    end else if (sym_q == 8'h64 && num2_q == '0) begin
                        // Refuse to hand a divide-by-zero downstream.
                        err_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
                is_clr: begin
                    clear_all = 1'b1;
                end
`ifdef BACKSPACE_EN
                is_bs: begin
                    if (state_q == OPA) begin
                        if (cnt1_q != '0) begin
                            num1_d = num1_q >> 4;
                            cnt1_d = cnt1_q - CONE;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (cnt2_q != '0) begin
                        num2_d = num2_q >> 4;
                        cnt2_d = cnt2_q - CONE;
                    end else begin
                        // Backing over the operator reopens operand 1.
                        sym_d   = 8'h00;
                        state_d = OPA;
                    end
                end
`endif
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end

        if (clear_all) begin
            state_d = OPA;
            num1_d  = '0;
            num2_d  = '0;
            cnt1_d  = '0;
            cnt2_d  = '0;
            sym_d   = 8'h00;
        end

        key_ready_d = (state_d != DONE);
        op_valid_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= OPA;
            num1_q      <= '0;
            num2_q      <= '0;
            cnt1_q      <= '0;
            cnt2_q      <= '0;
            sym_q       <= 8'h00;
            key_ready_q <= 1'b1;
            op_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            num1_q      <= num1_d;
            num2_q      <= num2_d;
            cnt1_q      <= cnt1_d;
            cnt2_q      <= cnt2_d;
            sym_q       <= sym_d;
            key_ready_q <= key_ready_d;
            op_valid_q  <= op_valid_d;
            err_q       <= err_d;
        end
    end

    assign key_ready = key_ready_q;
    assign op_valid  = op_valid_q;
    assign err       = err_q;
    assign reg_num1  = num1_q;
    assign reg_num2  = num2_q;
    assign cnt1      = cnt1_q;
    assign cnt2      = cnt2_q;
    assign sym       = sym_q;

endmodule
